// File: rtl/seq_scan_pkg.sv
// rtl/seq_scan_pkg.sv - shared constants, controller states and count helper for the serial pattern scanner
package seq_scan_pkg;

  localparam int NBITS_DEF = 16;
  localparam int CNT_W     = $clog2(NBITS_DEF + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Match count tops out at one detection per serialized bit.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_W'(NBITS_DEF)) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// rtl/seq_scan_ctrl_if.sv - run request and result bundle between a host and the scanner
interface seq_scan_ctrl_if;
  import seq_scan_pkg::*;

  logic                 start;
  logic [NBITS_DEF-1:0] data_in;
  logic                 busy;
  logic                 done;
  logic                 ser_bit;
  logic [CNT_W-1:0]     match_cnt;
  logic [NBITS_DEF-1:0] match_map;

  modport master (
    output start, data_in,
    input  busy, done, ser_bit, match_cnt, match_map
  );

  modport slave (
    input  start, data_in,
    output busy, done, ser_bit, match_cnt, match_map
  );

endinterface

// File: rtl/moore_det.sv
// rtl/moore_det.sv - overlapping Moore detector for a 4-bit pattern, PAT[3] arriving first
module moore_det #(
  parameter logic [3:0] PAT = 4'b1011
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inp,
  output logic out
);

  logic [3:0] hist;
  logic [2:0] fill;

  // fill keeps a partially loaded window from matching a pattern with zeros in it.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hist <= '0;
      fill <= '0;
    end else begin
      hist <= {hist[2:0], inp};
      if (fill != 3'd4) fill <= fill + 3'd1;
    end
  end

  assign out = (fill == 3'd4) && (hist == PAT);

endmodule

// File: rtl/seq_scan_ctrl.sv
// rtl/seq_scan_ctrl.sv - serializes a captured word LSB first through moore_det and records each completion
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter logic [3:0] PAT   = 4'b1011,
  parameter int         NBITS = NBITS_DEF
) (
  input  logic           clk,
  input  logic           rst,
  seq_scan_ctrl_if.slave bus
);

  localparam int KW = $clog2(NBITS);

  state_t           state;
  logic [KW-1:0]    k;
  logic [NBITS-1:0] sr;
  logic             det_clr;
  logic             det_out;
  logic             rec;
  logic [KW-1:0]    rec_idx;

  assign det_clr = (state == ST_IDLE) && bus.start;

  // Detector output lags the presented bit by one cycle, so it belongs to bit k-1 (bit NBITS-1 in DRAIN).
  always_comb begin
    rec     = 1'b0;
    rec_idx = k - 1'b1;
    if (state == ST_SHIFT) begin
      rec = det_out && (k != '0);
    end else if (state == ST_DRAIN) begin
      rec     = det_out;
      rec_idx = KW'(NBITS - 1);
    end
  end

  moore_det #(.PAT(PAT)) u_det (
    .clk (clk),
    .rst (rst),
    .clr (det_clr),
    .inp (bus.ser_bit),
    .out (det_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      k             <= '0;
      sr            <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.ser_bit   <= 1'b0;
      bus.match_cnt <= '0;
      bus.match_map <= '0;
    end else begin
      if (rec) begin
        bus.match_map[rec_idx] <= 1'b1;
        bus.match_cnt          <= sat_inc(bus.match_cnt);
      end
      case (state)
        ST_IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            sr            <= bus.data_in >> 1;
            bus.ser_bit   <= bus.data_in[0];
            bus.match_cnt <= '0;
            bus.match_map <= '0;
            k             <= '0;
            bus.busy      <= 1'b1;
            state         <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (k == KW'(NBITS - 1)) begin
            bus.ser_bit <= 1'b0;
            state       <= ST_DRAIN;
          end else begin
            k           <= k + 1'b1;
            bus.ser_bit <= sr[0];
            sr          <= sr >> 1;
          end
        end
        ST_DRAIN: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          state    <= ST_DONE;
        end
        default: begin
          bus.done <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb/tb_seq_scan_ctrl.sv - randomized scanner runs checked against a window-scan reference
module tb_seq_scan_ctrl;
  import seq_scan_pkg::*;

  localparam logic [3:0] PAT = 4'b1011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  seq_scan_ctrl_if bus ();

  seq_scan_ctrl #(.PAT(PAT), .NBITS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: slide a 4-bit window over the word in arrival order; bit k completes a match.
  task automatic model(input logic [15:0] d, output logic [15:0] m, output logic [4:0] c);
    logic [3:0] w;
    int n;
    m = '0;
    n = 0;
    for (int i = 3; i < 16; i++) begin
      w = {d[i-3], d[i-2], d[i-1], d[i]};
      if (w == PAT) begin
        m[i] = 1'b1;
        n++;
      end
    end
    if (n > 16) n = 16;
    c = 5'(n);
  endtask

  task automatic do_run(input logic [15:0] d, input string tag);
    logic [15:0] em;
    logic [4:0]  ec;
    logic [15:0] ser_seen;
    int busy_n;
    int cyc;
    model(d, em, ec);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = d;
    cyc = 0;
    ser_seen = '0;
    busy_n = 0;
    do begin
      @(negedge clk);
      cyc++;
      bus.start   = 1'($urandom_range(0, 1));
      bus.data_in = 16'($urandom);
      if (cyc >= 1 && cyc <= 16) ser_seen[cyc-1] = bus.ser_bit;
      if (bus.busy) busy_n++;
    end while (!bus.done && cyc < 40);
    bus.start = 1'b0;
    check({tag, "_latency"}, cyc, 18);
    check({tag, "_ser"}, ser_seen, d);
    check({tag, "_busy"}, busy_n, 17);
    check({tag, "_cnt"}, bus.match_cnt, ec);
    check({tag, "_map"}, bus.match_map, em);
    repeat (2) @(negedge clk);
    check({tag, "_done_low"}, bus.done, 1'b0);
    check({tag, "_ser_idle"}, bus.ser_bit, 1'b0);
    check({tag, "_map_stable"}, bus.match_map, em);
  endtask

  initial begin
    logic [15:0] em;
    logic [4:0]  ec;
    int n_done;
    int exp_cyc;
    bus.start   = 1'b0;
    bus.data_in = '0;

    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_ser", bus.ser_bit, 1'b0);
    check("rst_cnt", bus.match_cnt, 5'd0);
    check("rst_map", bus.match_map, 16'h0);
    rst = 1'b0;

    do_run(16'hDB6D, "db6d");
    check("db6d_const_cnt", bus.match_cnt, 5'd5);
    check("db6d_const_map", bus.match_map, 16'h9248);
    do_run(16'hA1C5, "a1c5");
    check("a1c5_const_map", bus.match_map, 16'h0000);
    do_run(16'hA000, "carry_a");
    do_run(16'h0001, "carry_b");
    check("carry_b_cnt0", bus.match_cnt, 5'd0);
    do_run(16'hFFFF, "ones");
    do_run(16'h0000, "zeros");

    // Abort mid-run: reset in SHIFT cycle k=8.
    model(16'hDB6D, em, ec);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = 16'hDB6D;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_busy", bus.busy, 1'b1);
    check("mid_map", bus.match_map, em & 16'h007F);
    check("mid_cnt", bus.match_cnt, 5'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_cnt", bus.match_cnt, 5'd0);
    check("abort_map", bus.match_map, 16'h0);
    check("abort_ser", bus.ser_bit, 1'b0);
    n_done = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("abort_no_done", n_done, 0);

    // Reset wins over a start in the same cycle.
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    bus.data_in = 16'hDB6D;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    check("rst_start_busy", bus.busy, 1'b0);
    n_done = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("rst_start_no_done", n_done, 0);

    // start held high: back-to-back runs every 19 cycles.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = 16'hDB6D;
    n_done = 0;
    for (int c = 1; c <= 80 && n_done < 3; c++) begin
      @(negedge clk);
      if (bus.done) begin
        exp_cyc = 18 + 19 * n_done;
        check($sformatf("held_run%0d_cyc", n_done), c, exp_cyc);
        check($sformatf("held_run%0d_cnt", n_done), bus.match_cnt, 5'd5);
        check($sformatf("held_run%0d_map", n_done), bus.match_map, 16'h9248);
        n_done++;
        if (n_done == 3) bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check("held_runs", n_done, 3);
    repeat (25) @(negedge clk);

    for (int r = 0; r < 20; r++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if (r % 4 == 0) w = w | 16'h0D0D;
      do_run(w, $sformatf("rand%0d", r));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
